// File: rtl/rps_match_ctrl_if.sv
// Match controller bus: player-side strobes in,
// round results, scores and match status out.
interface rps_match_ctrl_if #(
  parameter int CW = 4
);
  logic          throw;
  logic [1:0]    player;
  logic          new_match;
  logic [1:0]    computer;
  logic [1:0]    winner;
  logic          result_valid;
  logic [CW-1:0] player_score;
  logic [CW-1:0] cpu_score;
  logic [CW-1:0] round_cnt;
  logic          busy;
  logic          match_done;
  logic [1:0]    match_winner;

  modport master (
    output throw, player, new_match,
    input  computer, winner, result_valid,
    input  player_score, cpu_score, round_cnt,
    input  busy, match_done, match_winner
  );

  modport slave (
    input  throw, player, new_match,
    output computer, winner, result_valid,
    output player_score, cpu_score, round_cnt,
    output busy, match_done, match_winner
  );
endinterface

// File: rtl/rps_match_ctrl.sv
// Best-of-N rock-paper-scissors match controller:
// mod-3 spinner, 1-cycle round eval, hold, match decision.
module rps_match_ctrl #(
  parameter int WIN_SCORE   = 3,
  parameter int MAX_ROUNDS  = 15,
  parameter int HOLD_CYCLES = 4
) (
  input logic              clk,
  input logic              clear_b,
  rps_match_ctrl_if.slave  bus
);
  localparam int CW = $clog2(MAX_ROUNDS + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0] SCI   = 2'b00;
  localparam logic [1:0] ROCK  = 2'b01;
  localparam logic [1:0] PAPER = 2'b10;
  localparam logic [1:0] BAD   = 2'b11;

  localparam logic [1:0] W_PLY  = 2'b00;
  localparam logic [1:0] W_CPU  = 2'b01;
  localparam logic [1:0] W_NONE = 2'b10;
  localparam logic [1:0] W_DRAW = 2'b11;

  typedef enum logic [1:0] {
    IDLE, EVAL, HOLD, DONE
  } state_t;

  state_t        state;
  logic [1:0]    spin;
  logic [1:0]    player_q;
  logic [1:0]    computer;
  logic [1:0]    winner;
  logic          result_valid;
  logic [CW-1:0] player_score;
  logic [CW-1:0] cpu_score;
  logic [CW-1:0] round_cnt;
  logic [HW-1:0] hold_cnt;
  logic          busy;
  logic          match_done;
  logic [1:0]    match_winner;

  logic          p_beats;
  logic [1:0]    rnd_w;

  assign p_beats =
    (player_q == ROCK  && computer == SCI)  ||
    (player_q == PAPER && computer == ROCK) ||
    (player_q == SCI   && computer == PAPER);

  always_comb begin
    rnd_w = W_CPU;
    unique case (1'b1)
      (player_q == BAD):      rnd_w = W_CPU;
      (player_q == computer): rnd_w = W_DRAW;
      p_beats:                rnd_w = W_PLY;
      default:                rnd_w = W_CPU;
    endcase
  end

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      state        <= IDLE;
      spin         <= 2'd0;
      player_q     <= 2'd0;
      computer     <= 2'd0;
      winner       <= W_NONE;
      result_valid <= 1'b0;
      player_score <= '0;
      cpu_score    <= '0;
      round_cnt    <= '0;
      hold_cnt     <= '0;
      busy         <= 1'b0;
      match_done   <= 1'b0;
      match_winner <= W_NONE;
    end else begin
      spin         <= (spin == 2'd2) ? 2'd0
                                     : spin + 2'd1;
      result_valid <= 1'b0;
      if (bus.new_match) begin
        state        <= IDLE;
        winner       <= W_NONE;
        player_score <= '0;
        cpu_score    <= '0;
        round_cnt    <= '0;
        hold_cnt     <= '0;
        busy         <= 1'b0;
        match_done   <= 1'b0;
        match_winner <= W_NONE;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.throw) begin
              player_q <= bus.player;
              computer <= spin;
              busy     <= 1'b1;
              state    <= EVAL;
            end
          end
          EVAL: begin
            winner <= rnd_w;
            if (rnd_w == W_PLY)
              player_score <= player_score + CW'(1);
            if (rnd_w == W_CPU)
              cpu_score <= cpu_score + CW'(1);
            round_cnt    <= round_cnt + CW'(1);
            result_valid <= 1'b1;
            hold_cnt     <= HW'(HOLD_CYCLES - 1);
            state        <= HOLD;
          end
          HOLD: begin
            if (hold_cnt == '0) begin
              busy <= 1'b0;
              if (player_score == CW'(WIN_SCORE)) begin
                state        <= DONE;
                match_done   <= 1'b1;
                match_winner <= W_PLY;
              end else if (cpu_score == CW'(WIN_SCORE)) begin
                state        <= DONE;
                match_done   <= 1'b1;
                match_winner <= W_CPU;
              end else if (round_cnt == CW'(MAX_ROUNDS)) begin
                state        <= DONE;
                match_done   <= 1'b1;
                match_winner <= W_DRAW;
              end else begin
                state <= IDLE;
              end
            end else begin
              hold_cnt <= hold_cnt - HW'(1);
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.computer     = computer;
  assign bus.winner       = winner;
  assign bus.result_valid = result_valid;
  assign bus.player_score = player_score;
  assign bus.cpu_score    = cpu_score;
  assign bus.round_cnt    = round_cnt;
  assign bus.busy         = busy;
  assign bus.match_done   = match_done;
  assign bus.match_winner = match_winner;
endmodule

// File: tb/tb_rps_match_ctrl.sv
// Scoreboard bench for rps_match_ctrl with a
// 4-round limit, 3 wins to take, 4-cycle hold.
module tb_rps_match_ctrl;
  localparam int WS = 3;
  localparam int MR = 4;
  localparam int HC = 4;
  localparam int CW = 3;

  typedef struct {
    logic [1:0] c;
    logic [1:0] w;
    logic [2:0] ps;
    logic [2:0] cs;
    logic [2:0] rc;
  } exp_t;

  logic clk = 1'b0;
  logic clear_b = 1'b0;
  int   total = 0;
  int   bad = 0;
  int unsigned edges;
  exp_t exp_q[$];
  time  rv_t[$];
  int   mps, mcs, mrc;

  rps_match_ctrl_if #(.CW(CW)) bus ();

  rps_match_ctrl #(
    .WIN_SCORE(WS),
    .MAX_ROUNDS(MR),
    .HOLD_CYCLES(HC)
  ) dut (
    .clk(clk),
    .clear_b(clear_b),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // reference spinner: pre-edge spin = edges since reset mod 3
  always @(posedge clk or negedge clear_b)
    if (!clear_b) edges <= 0;
    else edges <= edges + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  function automatic logic [1:0] ref_win(
      input logic [1:0] p, input logic [1:0] c);
    if (p == 2'b11) return 2'b01;
    if (p == c) return 2'b11;
    case ({p, c})
      4'b0100, 4'b1001, 4'b0010: return 2'b00;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] beat(
      input logic [1:0] c);
    case (c)
      2'b00:   return 2'b01;
      2'b01:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic push_exp(input logic [1:0] c,
                          input logic [1:0] p);
    exp_t e;
    e.c = c;
    e.w = ref_win(p, c);
    if (e.w == 2'b00) mps++;
    if (e.w == 2'b01) mcs++;
    mrc++;
    e.ps = 3'(mps);
    e.cs = 3'(mcs);
    e.rc = 3'(mrc);
    exp_q.push_back(e);
  endtask

  // entered and left at a falling edge
  // kind: 0 given move, 1 force draw, 2 force player win
  task automatic throw_round(input int kind,
                             input logic [1:0] p);
    logic [1:0] c, pp;
    c = 2'(edges % 3);
    pp = (kind == 1) ? c : (kind == 2) ? beat(c) : p;
    push_exp(c, pp);
    bus.throw = 1'b1;
    bus.player = pp;
    @(negedge clk);
    bus.throw = 1'b0;
    chk("busy_eval", 32'(bus.busy), 1);
    repeat (HC + 1) @(negedge clk);
  endtask

  task automatic wait_spin(input int s);
    for (int i = 0; i < 3; i++)
      if (edges % 3 != s) @(negedge clk);
  endtask

  task automatic model_clear();
    mps = 0;
    mcs = 0;
    mrc = 0;
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, "_ps"}, 32'(bus.player_score), 0);
    chk({nm, "_cs"}, 32'(bus.cpu_score), 0);
    chk({nm, "_rc"}, 32'(bus.round_cnt), 0);
    chk({nm, "_win"}, 32'(bus.winner), 2);
    chk({nm, "_done"}, 32'(bus.match_done), 0);
    chk({nm, "_mw"}, 32'(bus.match_winner), 2);
    chk({nm, "_busy"}, 32'(bus.busy), 0);
  endtask

  task automatic pulse_new_match();
    bus.new_match = 1'b1;
    @(negedge clk);
    bus.new_match = 1'b0;
    model_clear();
  endtask

  // monitor: pops one expectation per result pulse
  always @(posedge clk) begin
    #1;
    if (bus.result_valid) begin
      rv_t.push_back($time);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_computer", 32'(bus.computer), 32'(e.c));
        chk("mon_winner", 32'(bus.winner), 32'(e.w));
        chk("mon_pscore", 32'(bus.player_score), 32'(e.ps));
        chk("mon_cscore", 32'(bus.cpu_score), 32'(e.cs));
        chk("mon_rounds", 32'(bus.round_cnt), 32'(e.rc));
        chk("mon_busy", 32'(bus.busy), 1);
      end
    end
  end

  initial begin
    bus.throw = 1'b0;
    bus.player = 2'b00;
    bus.new_match = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_computer", 32'(bus.computer), 0);
    chk("rst_rv", 32'(bus.result_valid), 0);
    chk_cleared("rst");
    @(negedge clk);
    clear_b = 1'b1;

    // rock vs scissors, then paper draw, then illegal
    throw_round(0, 2'b01);
    wait_spin(2);
    throw_round(0, 2'b10);
    throw_round(0, 2'b11);

    // new_match while holding
    push_exp(2'(edges % 3), 2'b01);
    bus.throw = 1'b1;
    bus.player = 2'b01;
    @(negedge clk);
    bus.throw = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_busy", 32'(bus.busy), 1);
    pulse_new_match();
    chk_cleared("nm_hold");

    // new_match beats a simultaneous throw
    bus.throw = 1'b1;
    bus.new_match = 1'b1;
    @(negedge clk);
    bus.throw = 1'b0;
    bus.new_match = 1'b0;
    @(negedge clk);
    chk("prio_busy", 32'(bus.busy), 0);
    chk("prio_rv", 32'(bus.result_valid), 0);

    // spinner kept running across new_match
    throw_round(2, 2'b00);
    pulse_new_match();

    // four draws reach the round limit
    for (int i = 0; i < MR; i++) throw_round(1, 2'b00);
    chk("lim_done", 32'(bus.match_done), 1);
    chk("lim_mw", 32'(bus.match_winner), 3);
    chk("lim_rc", 32'(bus.round_cnt), MR);
    chk("lim_busy", 32'(bus.busy), 0);
    pulse_new_match();
    chk_cleared("nm_done");

    // throw held high: one round per 6 cycles, player sweeps
    begin
      logic [1:0] c;
      c = 2'(edges % 3);
      rv_t.delete();
      for (int i = 0; i < WS; i++) push_exp(c, beat(c));
      bus.player = beat(c);
      bus.throw = 1'b1;
      repeat (30) @(negedge clk);
      chk("held_pulses", 32'(rv_t.size()), WS);
      if (rv_t.size() == WS) begin
        chk("held_gap1", 32'(rv_t[1] - rv_t[0]), 60);
        chk("held_gap2", 32'(rv_t[2] - rv_t[1]), 60);
      end
      chk("win_done", 32'(bus.match_done), 1);
      chk("win_mw", 32'(bus.match_winner), 0);
      chk("win_ps", 32'(bus.player_score), WS);
      chk("win_rc", 32'(bus.round_cnt), WS);
      bus.throw = 1'b0;
    end

    // async clear in EVAL
    bus.throw = 1'b1;
    bus.player = 2'b01;
    @(negedge clk);
    bus.throw = 1'b0;
    #2;
    clear_b = 1'b0;
    #1;
    chk("arst_computer", 32'(bus.computer), 0);
    chk("arst_rv", 32'(bus.result_valid), 0);
    chk_cleared("arst");
    model_clear();
    @(negedge clk);
    clear_b = 1'b1;
    throw_round(2, 2'b00);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rps_match_ctrl.md
Name: rps_match_ctrl

Overview:
Best-of-N rock-paper-scissors match controller, parametrised successor to the single-round game block. It holds a free-running mod-3 computer-move generator and samples the player's move on a throw strobe. It resolves each round with a fixed latency, keeps per-side scores and a round count, and declares a match winner. It sits between the player input debouncer and the score/display logic of the arcade top level.

Parameters:
WIN_SCORE, 3, round wins needed to take the match (1..MAX_ROUNDS).
MAX_ROUNDS, 15, round limit; reaching it without a winner ends the match as a draw.
HOLD_CYCLES, 4, cycles (>=1) the result is held before the next throw is accepted.
CW (localparam), $clog2(MAX_ROUNDS+1), width of the score and round counters.

Ports:
clk  in  1  system clock, all logic on rising edge
clear_b  in  1  asynchronous active-low reset
throw  in  1  strobe; sampled only in IDLE
player  in  2  player move: 00 scissors, 01 rock, 10 paper, 11 illegal
new_match  in  1  synchronous match restart, any state
computer  out  2  computer move latched for the current round
winner  out  2  round result: 00 player, 01 computer, 11 draw, 10 no result
result_valid  out  1  one-cycle pulse when winner/scores update
player_score  out  CW  player round wins
cpu_score  out  CW  computer round wins
round_cnt  out  CW  rounds played this match
busy  out  1  high in EVAL and HOLD
match_done  out  1  high in DONE
match_winner  out  2  00 player, 01 computer, 11 draw, 10 undecided

Behaviour:
- Async reset (clear_b=0): state IDLE; spin=0; computer=00; winner=10; match_winner=10; scores, round_cnt, hold counter = 0; result_valid, busy, match_done = 0.
- spin: 2-bit free-running counter with sequence 0,1,2,0; advances every edge in every state. Only async reset clears it; new_match does not.
- States: IDLE, EVAL, HOLD, DONE.
- IDLE: on an edge with throw=1, latch player_q<=player and computer<=spin (the pre-edge value); go to EVAL. throw=0 stays in IDLE.
- EVAL (exactly 1 cycle):
  - Register winner: equal moves give draw (11); rock beats scissors, paper beats rock, scissors beats paper.
  - player_q=11 is a computer win (01), including when computer=11 cannot occur.
  - Increment the winning side's score; a draw scores nobody. round_cnt+1.
  - result_valid=1 for the single cycle after this edge.
  - Load the hold counter with HOLD_CYCLES-1; go to HOLD.
- Latency: throw sampled at edge N; winner, scores and result_valid visible after edge N+1.
- HOLD: hold counter decrements each edge. At 0, exit to DONE or IDLE.
  - DONE if player_score==WIN_SCORE: match_winner=00.
  - Else DONE if cpu_score==WIN_SCORE: match_winner=01.
  - Else DONE if round_cnt==MAX_ROUNDS: match_winner=11.
  - Else IDLE.
  - throw is ignored throughout HOLD.
- DONE: match_done=1; all outputs frozen; throw ignored.
- new_match=1 at any edge, in any state:
  - Next state IDLE; scores and round_cnt to 0; winner=10; match_winner=10; match_done=0; result_valid=0.
  - computer keeps its last value.
  - new_match has priority over throw and over any pending transition.
- Only one side can score per round, so a win condition and the round limit can never conflict; the win takes precedence.
- Counters never exceed WIN_SCORE or MAX_ROUNDS, so no wrap is possible.
- throw held high re-triggers on the first IDLE edge after HOLD.

Test Plan:
- Release reset; first edge: throw=1, player=01 (spin=0) -> next edge: computer=00, winner=00, player_score=1, round_cnt=1, result_valid one cycle, busy=1.
- Throw player=10 when spin=2 -> winner=11, both scores unchanged, round_cnt+1. Throw player=11 -> winner=01, cpu_score+1.
- throw held high continuously -> exactly one round per 1+1+HOLD_CYCLES cycles (6 cycles at defaults); no throws accepted during HOLD.
- Player wins 3 rounds with WIN_SCORE=3 -> after HOLD: match_done=1, match_winner=00. Further throws leave scores at 3.
- MAX_ROUNDS=4 with four draws -> match_done=1, match_winner=11, round_cnt=4.
- new_match pulsed mid-HOLD and in DONE -> next cycle IDLE, scores=0, winner=10, match_done=0, spin continues. Async clear_b low mid-EVAL -> all reset values immediately.
